rotate_coord_gen: RTL and testbench
===================================

// Module: rotate_coord_gen
// PURPOSE
// Pipelined raster-scan generator of rotated source coordinates for the imager rotate path. On start it scans
// every output pixel (row-major), rotates it about the image centre by (cos,sin), and emits signed sub-pixel
// source coordinates with an out-of-bounds flag and frame markers over a valid/ready stream to the resampler.
// PARAMETERS
// IN_WIDTH    12  unsigned pixel index / dimension width
// ANGLE_WIDTH 10  signed cos/sin width; fraction bits AF = ANGLE_WIDTH-2 (256 = 1.0 at default)
// FRAC_BITS   4   sub-pixel fraction bits on outputs; must satisfy 0 <= FRAC_BITS <= AF
// ROUND       1   1 = round half up when dropping AF-FRAC_BITS bits, 0 = truncate (floor)
// localparam OUT_WIDTH = IN_WIDTH+FRAC_BITS+2 (sign + overflow bit)
// PORTS
// clk        in   1              single clock, all logic rising edge
// resetb     in   1              synchronous active-low reset
// start      in   1              pulse: latch config, begin frame (ignored while busy)
// cos_theta  in   ANGLE_WIDTH    signed, sampled on accepted start
// sin_theta  in   ANGLE_WIDTH    signed, sampled on accepted start
// num_cols   in   IN_WIDTH       frame width, sampled on accepted start
// num_rows   in   IN_WIDTH       frame height, sampled on accepted start
// busy       out  1              frame in progress
// out_valid  out  1              output beat valid
// out_ready  in   1              downstream accepts beat
// xo, yo     out  OUT_WIDTH      signed source coords, FRAC_BITS fraction
// oob        out  1              integer part of xo/yo outside [0,num_cols-1]/[0,num_rows-1]
// sof,eol,eof out 1 each         first pixel / last in row / last in frame, qualified by out_valid
// BEHAVIOUR
// - Reset (resetb=0 at edge): busy=0, out_valid=0, xo=yo=0, oob=sof=eol=eof=0, counters and pipe valids
//   cleared; applies mid-frame, frame abandoned, no further beats.
// - Start accepted when start=1, busy=0, num_cols!=0, num_rows!=0; else ignored (busy stays 0). busy=1 next cycle.
// - States: IDLE -> SCAN (counter xi/yi issues pixels) -> DRAIN (counter done, pipe non-empty) -> IDLE.
//   SCAN->DRAIN when pixel (num_cols-1,num_rows-1) issued; DRAIN->IDLE when eof beat accepted; busy=0 in IDLE.
// - Counter: xi 0..num_cols-1 wraps to 0 and increments yi; issues one pixel per advancing cycle.
// - Pipe (3 stages, advance = !out_valid | out_ready, all stages hold together on stall):
//   S1 xc=xi-(num_cols>>1), yc=yi-(num_rows>>1), signed IN_WIDTH+1.
//   S2 four products xc*cos, yc*sin, xc*sin, yc*cos, signed IN_WIDTH+ANGLE_WIDTH+1 each.
//   S3 xr=xc*cos-yc*sin, yr=xc*sin+yc*cos (+1 bit); add (num_cols>>1)<<AF, (num_rows>>1)<<AF;
//      shift right arithmetic by AF-FRAC_BITS, adding 1<<(AF-FRAC_BITS-1) first if ROUND and AF>FRAC_BITS;
//      result sign-extended/truncated to OUT_WIDTH; oob from integer part (>>>FRAC_BITS) compare.
// - Latency: first beat out_valid 3 cycles after SCAN entry with out_ready=1; then 1 beat/cycle sustained.
// - Backpressure: out_valid=1 & out_ready=0 -> xo,yo,oob,markers stable; no beat lost or duplicated.
// - Markers: sof on (0,0); eol on xi=num_cols-1; eof on last pixel (eol also 1). 1x1 frame: sof=eol=eof=1.
// - start while busy: ignored, no config change. Config inputs changing mid-frame: no effect.
// TESTING
// 1 Identity cos=256 sin=0, 4x4, ready=1 -> 16 beats, xo=xi*16, yo=yi*16, oob=0, sof on beat0, eol every 4th, eof beat15.
// 2 90deg cos=0 sin=256, 4x4 -> beat(0,0): xo=64, yo=0, oob=1; beat(2,2): xo=32, yo=32, oob=0.
// 3 45deg cos=sin=181, ROUND=1, 4x4 -> beat (xi=3,yi=2): xo=43, yo=43, oob=0; ROUND=0 same (floor 11).
// 4 Random out_ready (50%) on 8x3 frame -> exactly 24 beats, values equal to ready=1 run, held stable during stalls.
// 5 start pulses during busy and with num_cols=0 -> ignored; busy/out_valid unchanged, no extra beats.
// 6 resetb=0 for 1 cycle after beat 5 of 4x4 -> next cycle busy=0, out_valid=0; new start gives full 16 beats from sof.

Source files
------------

// File: rtl/rotate_coord_gen.sv
// Raster-scan generator of rotated sub-pixel source coordinates for the rotate path.
// A scan counter feeds a 3-stage centre/multiply/sum pipeline that drives a valid/ready stream.
module rotate_coord_gen #(
    parameter int IN_WIDTH    = 12,
    parameter int ANGLE_WIDTH = 10,
    parameter int FRAC_BITS   = 4,
    parameter int ROUND       = 1,
    localparam int OUT_WIDTH  = IN_WIDTH + FRAC_BITS + 2
) (
    input  logic                        clk,
    input  logic                        resetb,
    input  logic                        start,
    input  logic signed [ANGLE_WIDTH-1:0] cos_theta,
    input  logic signed [ANGLE_WIDTH-1:0] sin_theta,
    input  logic [IN_WIDTH-1:0]         num_cols,
    input  logic [IN_WIDTH-1:0]         num_rows,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] xo,
    output logic signed [OUT_WIDTH-1:0] yo,
    output logic                        oob,
    output logic                        sof,
    output logic                        eol,
    output logic                        eof
);

    localparam int AF      = ANGLE_WIDTH - 2;
    localparam int SH      = AF - FRAC_BITS;
    localparam int XC_W    = IN_WIDTH + 1;
    localparam int PR_W    = IN_WIDTH + ANGLE_WIDTH + 1;
    localparam int SUM_W   = PR_W + 2;
    localparam int INT_W   = OUT_WIDTH - FRAC_BITS;
    localparam int RND_INT = (ROUND != 0 && SH > 0) ? (1 << ((SH > 0) ? SH - 1 : 0)) : 0;
    localparam logic signed [SUM_W-1:0] RND_ADD = SUM_W'(RND_INT);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t state, state_nxt;

    logic signed [ANGLE_WIDTH-1:0] cos_q, sin_q;
    logic [IN_WIDTH-1:0]           cols_q, rows_q;
    logic [IN_WIDTH-1:0]           cols_half, rows_half, col_last, row_last;
    logic [IN_WIDTH-1:0]           xi, yi;
    logic                          start_acc, advance, last_px;

    logic signed [XC_W-1:0]        xc_p0, yc_p0;
    logic                          sof_p0, eol_p0, eof_p0, vld_p0;
    logic signed [PR_W-1:0]        xcos_p1, ysin_p1, xsin_p1, ycos_p1;
    logic                          sof_p1, eol_p1, eof_p1, vld_p1;
    logic signed [OUT_WIDTH-1:0]   xo_p2, yo_p2;
    logic                          oob_p2, sof_p2, eol_p2, eof_p2, vld_p2;

    logic signed [SUM_W-1:0]       ctr_x, ctr_y, sum_x, sum_y;
    logic signed [OUT_WIDTH-1:0]   xo_n, yo_n;
    logic signed [INT_W-1:0]       ix, iy;
    logic                          oob_n;

    // Drop AF-FRAC_BITS fraction bits, optionally rounding half up, then fit to the output width.
    function automatic logic signed [OUT_WIDTH-1:0] scale_round(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] t;
        t = (v + RND_ADD) >>> SH;
        return OUT_WIDTH'(t);
    endfunction

    assign cols_half = cols_q >> 1;
    assign rows_half = rows_q >> 1;
    assign col_last  = cols_q - IN_WIDTH'(1);
    assign row_last  = rows_q - IN_WIDTH'(1);
    assign ctr_x     = $signed(SUM_W'({cols_half, {AF{1'b0}}}));
    assign ctr_y     = $signed(SUM_W'({rows_half, {AF{1'b0}}}));

    assign advance   = !vld_p2 || out_ready;
    assign start_acc = start && (state == IDLE) && (num_cols != '0) && (num_rows != '0);
    assign last_px   = (xi == col_last) && (yi == row_last);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = SCAN;
            SCAN:    if (advance && last_px) state_nxt = DRAIN;
            DRAIN:   if (vld_p2 && out_ready && eof_p2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
            xi    <= '0;
            yi    <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                xi <= '0;
                yi <= '0;
            end else if (state == SCAN && advance) begin
                if (xi == col_last) begin
                    xi <= '0;
                    yi <= yi + IN_WIDTH'(1);
                end else begin
                    xi <= xi + IN_WIDTH'(1);
                end
            end
        end
    end

    // Frame configuration is frozen for the whole frame once start is accepted.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            cos_q  <= cos_theta;
            sin_q  <= sin_theta;
            cols_q <= num_cols;
            rows_q <= num_rows;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= (state == SCAN);
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            // S1: centre the scan position
            xc_p0   <= $signed({1'b0, xi}) - $signed({1'b0, cols_half});
            yc_p0   <= $signed({1'b0, yi}) - $signed({1'b0, rows_half});
            sof_p0  <= (xi == '0) && (yi == '0);
            eol_p0  <= (xi == col_last);
            eof_p0  <= last_px;
            // S2: rotation products
            xcos_p1 <= PR_W'(xc_p0) * PR_W'(cos_q);
            ysin_p1 <= PR_W'(yc_p0) * PR_W'(sin_q);
            xsin_p1 <= PR_W'(xc_p0) * PR_W'(sin_q);
            ycos_p1 <= PR_W'(yc_p0) * PR_W'(cos_q);
            sof_p1  <= sof_p0;
            eol_p1  <= eol_p0;
            eof_p1  <= eof_p0;
        end
    end

    // S3: sum, re-centre, scale and bounds check
    always_comb begin
        sum_x = SUM_W'(xcos_p1) - SUM_W'(ysin_p1) + ctr_x;
        sum_y = SUM_W'(xsin_p1) + SUM_W'(ycos_p1) + ctr_y;
        xo_n  = scale_round(sum_x);
        yo_n  = scale_round(sum_y);
        ix    = INT_W'(xo_n >>> FRAC_BITS);
        iy    = INT_W'(yo_n >>> FRAC_BITS);
        oob_n = ix[INT_W-1] || iy[INT_W-1] ||
                (ix > $signed({2'b00, col_last})) || (iy > $signed({2'b00, row_last}));
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            xo_p2  <= '0;
            yo_p2  <= '0;
            oob_p2 <= 1'b0;
            sof_p2 <= 1'b0;
            eol_p2 <= 1'b0;
            eof_p2 <= 1'b0;
        end else if (advance && vld_p1) begin
            xo_p2  <= xo_n;
            yo_p2  <= yo_n;
            oob_p2 <= oob_n;
            sof_p2 <= sof_p1;
            eol_p2 <= eol_p1;
            eof_p2 <= eof_p1;
        end
    end

    assign out_valid = vld_p2;
    assign xo        = xo_p2;
    assign yo        = yo_p2;
    assign oob       = oob_p2;
    assign sof       = sof_p2;
    assign eol       = eol_p2;
    assign eof       = eof_p2;

endmodule

// File: tb/tb_rotate_coord_gen.sv
// Directed bench for rotate_coord_gen: a rounding and a truncating instance share one stimulus stream.
module tb_rotate_coord_gen;

    localparam int IW = 12;
    localparam int AW = 10;
    localparam int FB = 4;
    localparam int OW = IW + FB + 2;

    logic clk = 1'b0;
    logic resetb, start, out_ready;
    logic signed [AW-1:0] cos_theta, sin_theta;
    logic [IW-1:0] num_cols, num_rows;
    logic busy, out_valid, oob, sof, eol, eof;
    logic signed [OW-1:0] xo, yo;
    logic busy_t, out_valid_t, oob_t, sof_t, eol_t, eof_t;
    logic signed [OW-1:0] xo_t, yo_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    int cap_xo[64], cap_yo[64], cap_xo_t[64], cap_yo_t[64];
    logic cap_oob[64], cap_oob_t[64];
    logic [2:0] cap_mk[64], cap_mk_t[64];
    int cap_n, stall_changes, vt_mismatch;
    logic cap_timeout;

    always #5 clk = ~clk;

    rotate_coord_gen #(.IN_WIDTH(IW), .ANGLE_WIDTH(AW), .FRAC_BITS(FB), .ROUND(1)) dut (
        .clk(clk), .resetb(resetb), .start(start), .cos_theta(cos_theta), .sin_theta(sin_theta),
        .num_cols(num_cols), .num_rows(num_rows), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .xo(xo), .yo(yo), .oob(oob), .sof(sof), .eol(eol), .eof(eof)
    );

    rotate_coord_gen #(.IN_WIDTH(IW), .ANGLE_WIDTH(AW), .FRAC_BITS(FB), .ROUND(0)) dut_trunc (
        .clk(clk), .resetb(resetb), .start(start), .cos_theta(cos_theta), .sin_theta(sin_theta),
        .num_cols(num_cols), .num_rows(num_rows), .busy(busy_t), .out_valid(out_valid_t),
        .out_ready(out_ready), .xo(xo_t), .yo(yo_t), .oob(oob_t), .sof(sof_t), .eol(eol_t), .eof(eof_t)
    );

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic do_start(input int c, input int s, input int cols, input int rows);
        cos_theta = AW'(c);
        sin_theta = AW'(s);
        num_cols  = IW'(cols);
        num_rows  = IW'(rows);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Records every accepted beat until eof; ready_mode 0 = always ready, 1 = random.
    task automatic capture(input int ready_mode, input int pulse_cycle, input int max_cycles);
        logic signed [OW-1:0] pxo, pyo;
        logic [3:0] pflags;
        logic pstall, done;
        int cyc;
        for (int i = 0; i < 64; i++) begin
            cap_xo[i] = -999; cap_yo[i] = -999; cap_xo_t[i] = -999; cap_yo_t[i] = -999;
            cap_oob[i] = 1'bx; cap_oob_t[i] = 1'bx; cap_mk[i] = 3'bxxx; cap_mk_t[i] = 3'bxxx;
        end
        cap_n = 0; stall_changes = 0; vt_mismatch = 0; cap_timeout = 1'b0;
        pstall = 1'b0; done = 1'b0; cyc = 0; pxo = '0; pyo = '0; pflags = '0;
        while (!done) begin
            if (cyc >= max_cycles) begin
                cap_timeout = 1'b1;
                break;
            end
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cyc == pulse_cycle) begin
                start = 1'b1; cos_theta = '0; sin_theta = 10'sd100; num_cols = 12'd2; num_rows = 12'd7;
            end else begin
                start = 1'b0;
            end
            if (out_valid_t !== out_valid) vt_mismatch++;
            if (pstall && (xo !== pxo || yo !== pyo || {oob, sof, eol, eof} !== pflags || out_valid !== 1'b1))
                stall_changes++;
            if (out_valid && out_ready) begin
                if (cap_n < 64) begin
                    cap_xo[cap_n] = int'(xo);     cap_yo[cap_n] = int'(yo);
                    cap_xo_t[cap_n] = int'(xo_t); cap_yo_t[cap_n] = int'(yo_t);
                    cap_oob[cap_n] = oob;         cap_oob_t[cap_n] = oob_t;
                    cap_mk[cap_n] = {sof, eol, eof};
                    cap_mk_t[cap_n] = {sof_t, eol_t, eof_t};
                end
                cap_n++;
                if (eof) done = 1'b1;
            end
            pstall = out_valid && !out_ready;
            pxo = xo; pyo = yo; pflags = {oob, sof, eol, eof};
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetb = 1'b0; start = 1'b0; out_ready = 1'b1;
        cos_theta = '0; sin_theta = '0; num_cols = '0; num_rows = '0;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (xo !== '0 || yo !== '0) $display("FAIL reset_xy: got %0d,%0d want 0,0", xo, yo); else pass_cnt++;
        total_cnt++; if ({oob, sof, eol, eof} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {oob, sof, eol, eof}); else pass_cnt++;
        total_cnt++; if (busy_t !== 1'b0) $display("FAIL reset_busy_trunc: got %b want 0", busy_t); else pass_cnt++;
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lat;
        do_start(256, 0, 4, 4);
        total_cnt++; if (busy !== 1'b1) $display("FAIL id_busy: got %b want 1", busy); else pass_cnt++;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++; if (lat !== 4) $display("FAIL id_latency: got %0d want 4", lat); else pass_cnt++;
        capture(0, -1, 200);
        total_cnt++; if (cap_timeout !== 1'b0) $display("FAIL id_timeout: got %b want 0", cap_timeout); else pass_cnt++;
        total_cnt++; if (cap_n !== 16) $display("FAIL id_count: got %0d want 16", cap_n); else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            logic [2:0] emk;
            emk = {k == 0, (k % 4) == 3, k == 15};
            total_cnt++; if (cap_xo[k] !== (k % 4) * 16) $display("FAIL id_xo[%0d]: got %0d want %0d", k, cap_xo[k], (k % 4) * 16); else pass_cnt++;
            total_cnt++; if (cap_yo[k] !== (k / 4) * 16) $display("FAIL id_yo[%0d]: got %0d want %0d", k, cap_yo[k], (k / 4) * 16); else pass_cnt++;
            total_cnt++; if (cap_oob[k] !== 1'b0) $display("FAIL id_oob[%0d]: got %b want 0", k, cap_oob[k]); else pass_cnt++;
            total_cnt++; if (cap_mk[k] !== emk) $display("FAIL id_markers[%0d]: got %b want %b", k, cap_mk[k], emk); else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL id_idle: got busy=%b valid=%b want 0,0", busy, out_valid); else pass_cnt++;
    endtask

    task automatic test_rot90();
        do_start(0, 256, 4, 4);
        capture(0, -1, 200);
        total_cnt++; if (cap_n !== 16) $display("FAIL r90_count: got %0d want 16", cap_n); else pass_cnt++;
        total_cnt++; if (cap_xo[0] !== 64 || cap_yo[0] !== 0) $display("FAIL r90_b0_xy: got %0d,%0d want 64,0", cap_xo[0], cap_yo[0]); else pass_cnt++;
        total_cnt++; if (cap_oob[0] !== 1'b1) $display("FAIL r90_b0_oob: got %b want 1", cap_oob[0]); else pass_cnt++;
        total_cnt++; if (cap_xo[10] !== 32 || cap_yo[10] !== 32) $display("FAIL r90_b10_xy: got %0d,%0d want 32,32", cap_xo[10], cap_yo[10]); else pass_cnt++;
        total_cnt++; if (cap_oob[10] !== 1'b0) $display("FAIL r90_b10_oob: got %b want 0", cap_oob[10]); else pass_cnt++;
    endtask

    task automatic test_rot45();
        do_start(181, 181, 4, 4);
        capture(0, -1, 200);
        total_cnt++; if (cap_n !== 16) $display("FAIL r45_count: got %0d want 16", cap_n); else pass_cnt++;
        total_cnt++; if (vt_mismatch !== 0) $display("FAIL r45_valid_trunc: got %0d differing cycles want 0", vt_mismatch); else pass_cnt++;
        total_cnt++; if (cap_xo[11] !== 43 || cap_yo[11] !== 43) $display("FAIL r45_round_b11: got %0d,%0d want 43,43", cap_xo[11], cap_yo[11]); else pass_cnt++;
        total_cnt++; if (cap_xo_t[11] !== 43 || cap_yo_t[11] !== 43) $display("FAIL r45_trunc_b11: got %0d,%0d want 43,43", cap_xo_t[11], cap_yo_t[11]); else pass_cnt++;
        total_cnt++; if (cap_oob[11] !== 1'b0 || cap_oob_t[11] !== 1'b0) $display("FAIL r45_oob_b11: got %b,%b want 0,0", cap_oob[11], cap_oob_t[11]); else pass_cnt++;
        total_cnt++; if (cap_xo[2] !== 55 || cap_yo[2] !== 9) $display("FAIL r45_round_b2: got %0d,%0d want 55,9", cap_xo[2], cap_yo[2]); else pass_cnt++;
        total_cnt++; if (cap_xo_t[2] !== 54 || cap_yo_t[2] !== 9) $display("FAIL r45_trunc_b2: got %0d,%0d want 54,9", cap_xo_t[2], cap_yo_t[2]); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_start(256, 0, 8, 3);
        capture(1, -1, 2000);
        total_cnt++; if (cap_timeout !== 1'b0) $display("FAIL bp_timeout: got %b want 0", cap_timeout); else pass_cnt++;
        total_cnt++; if (cap_n !== 24) $display("FAIL bp_count: got %0d want 24", cap_n); else pass_cnt++;
        total_cnt++; if (stall_changes !== 0) $display("FAIL bp_stall_stable: got %0d changes want 0", stall_changes); else pass_cnt++;
        for (int k = 0; k < 24; k++) begin
            logic [2:0] emk;
            emk = {k == 0, (k % 8) == 7, k == 23};
            total_cnt++;
            if (cap_xo[k] !== (k % 8) * 16 || cap_yo[k] !== (k / 8) * 16 || cap_mk[k] !== emk)
                $display("FAIL bp_beat[%0d]: got %0d,%0d,%b want %0d,%0d,%b", k, cap_xo[k], cap_yo[k], cap_mk[k], (k % 8) * 16, (k / 8) * 16, emk);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        do_start(256, 0, 4, 4);
        capture(0, 3, 200);
        total_cnt++; if (cap_n !== 16) $display("FAIL ign_count: got %0d want 16", cap_n); else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (cap_xo[k] !== (k % 4) * 16 || cap_yo[k] !== (k / 4) * 16)
                $display("FAIL ign_beat[%0d]: got %0d,%0d want %0d,%0d", k, cap_xo[k], cap_yo[k], (k % 4) * 16, (k / 4) * 16);
            else pass_cnt++;
        end
        do_start(256, 0, 0, 4);
        total_cnt++; if (busy !== 1'b0) $display("FAIL ign_zero_cols_busy: got %b want 0", busy); else pass_cnt++;
        do_start(256, 0, 4, 0);
        total_cnt++; if (busy !== 1'b0) $display("FAIL ign_zero_rows_busy: got %b want 0", busy); else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL ign_no_beats: got valid=%b busy=%b want 0,0", out_valid, busy); else pass_cnt++;
    endtask

    task automatic test_one_pixel();
        do_start(256, 0, 1, 1);
        capture(0, -1, 100);
        total_cnt++; if (cap_n !== 1) $display("FAIL px1_count: got %0d want 1", cap_n); else pass_cnt++;
        total_cnt++; if (cap_mk[0] !== 3'b111) $display("FAIL px1_markers: got %b want 111", cap_mk[0]); else pass_cnt++;
        total_cnt++; if (cap_mk_t[0] !== 3'b111) $display("FAIL px1_markers_trunc: got %b want 111", cap_mk_t[0]); else pass_cnt++;
        total_cnt++; if (cap_xo[0] !== 0 || cap_yo[0] !== 0 || cap_oob[0] !== 1'b0) $display("FAIL px1_xy: got %0d,%0d,%b want 0,0,0", cap_xo[0], cap_yo[0], cap_oob[0]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        do_start(256, 0, 4, 4);
        n = 0; cyc = 0;
        while (n < 5 && cyc < 100) begin
            if (out_valid && out_ready) n++;
            @(negedge clk);
            cyc++;
        end
        total_cnt++; if (n !== 5) $display("FAIL rst_pre_beats: got %0d want 5", n); else pass_cnt++;
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_mid_ctrl: got busy=%b valid=%b want 0,0", busy, out_valid); else pass_cnt++;
        total_cnt++; if (xo !== '0 || sof !== 1'b0 || eof !== 1'b0) $display("FAIL rst_mid_data: got xo=%0d sof=%b eof=%b want 0,0,0", xo, sof, eof); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_no_beats: got %b want 0", out_valid); else pass_cnt++;
        do_start(256, 0, 4, 4);
        capture(0, -1, 200);
        total_cnt++; if (cap_n !== 16) $display("FAIL rst_restart_count: got %0d want 16", cap_n); else pass_cnt++;
        total_cnt++; if (cap_mk[0] !== 3'b100 || cap_xo[0] !== 0) $display("FAIL rst_restart_first: got %b,%0d want 100,0", cap_mk[0], cap_xo[0]); else pass_cnt++;
        total_cnt++; if (cap_mk[15] !== 3'b011 || cap_yo[15] !== 48) $display("FAIL rst_restart_last: got %b,%0d want 011,48", cap_mk[15], cap_yo[15]); else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_identity();
        test_rot90();
        test_rot45();
        test_backpressure();
        test_start_ignored();
        test_one_pixel();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
